// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap pass: walks i=0..255, accumulates j and swaps S[i]/S[j]
// through the single-port s_memory (one wait state per read).
//
// state   | meaning
// IDLE    | waiting for start; busy low
// RD_SI   | present address=i to memory
// WAIT_SI | read wait; capture S[i] at end of cycle
// CALC_J  | j += S[i] + key byte; present new j as address
// RD_SJ   | present address=j
// WAIT_SJ | read wait; capture S[j] at end of cycle
// WR_SI   | write S[j] to address i
// WR_SJ   | write S[i] to address j
// NEXT    | advance key index; next i or finish
// DONE    | one-cycle done pulse, then back to IDLE
module ksa_swap_fsm #(
  parameter int KEY_W     = 24,
  parameter int N_ENTRIES = 256
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [KEY_W-1:0] secret_key,
  input  logic [7:0]       q,
  output logic [7:0]       address,
  output logic [7:0]       data,
  output logic             wren,
  output logic             busy,
  output logic             done
);

  localparam logic [7:0] I_LAST = 8'(N_ENTRIES - 1);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WAIT_SI, CALC_J, RD_SJ, WAIT_SJ, WR_SI, WR_SJ, NEXT, DONE
  } state_t;

  state_t           state;
  logic [7:0]       i;
  logic [7:0]       j;
  logic [1:0]       kidx;
  logic [7:0]       si;
  logic [7:0]       sj;
  logic [KEY_W-1:0] key_r;
  logic [7:0]       key_byte;
  logic [7:0]       j_calc;

  always_comb begin
    key_byte = key_r[7:0];
    case (kidx)
      2'd0:    key_byte = key_r[KEY_W-1 -: 8];
      2'd1:    key_byte = key_r[KEY_W-9 -: 8];
      default: key_byte = key_r[7:0];
    endcase
    j_calc = j + si + key_byte;
  end

  // outputs are set on the edge entering the state that owns them
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      kidx    <= '0;
      si      <= '0;
      sj      <= '0;
      key_r   <= '0;
      address <= '0;
      data    <= '0;
      wren    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      wren <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            key_r   <= secret_key;
            i       <= '0;
            j       <= '0;
            kidx    <= '0;
            busy    <= 1'b1;
            address <= '0;
            state   <= RD_SI;
          end
        end
        RD_SI: begin
          address <= i;
          state   <= WAIT_SI;
        end
        WAIT_SI: begin
          si    <= q;
          state <= CALC_J;
        end
        CALC_J: begin
          j       <= j_calc;
          address <= j_calc;
          state   <= RD_SJ;
        end
        RD_SJ: begin
          address <= j;
          state   <= WAIT_SJ;
        end
        WAIT_SJ: begin
          sj      <= q;
          address <= i;
          data    <= q;
          wren    <= 1'b1;
          state   <= WR_SI;
        end
        WR_SI: begin
          address <= j;
          data    <= si;
          wren    <= 1'b1;
          state   <= WR_SJ;
        end
        WR_SJ: begin
          state <= NEXT;
        end
        NEXT: begin
          kidx <= (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
          if (i == I_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i       <= i + 8'd1;
            address <= i + 8'd1;
            state   <= RD_SI;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Bench for ksa_swap_fsm: synchronous-read memory model, software KSA reference,
// write scoreboard, and directed timing / disturbance / reset scenarios.
module tb_ksa_swap_fsm;

  logic        clk;
  logic        reset;
  logic        start;
  logic [23:0] secret_key;
  logic [7:0]  q;
  logic [7:0]  address;
  logic [7:0]  data;
  logic        wren;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] mem [256];
  logic [7:0] exp_s [256];
  wr_t        exp_q [$];
  wr_t        wlog [6];
  logic       mem_init;
  logic       sb_en;
  int         edge_cnt;
  int         wr_cnt;
  int         done_cnt;
  int         total;
  int         bad;

  ksa_swap_fsm #(.KEY_W(24), .N_ENTRIES(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .secret_key (secret_key),
    .q          (q),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // s_memory: address/data sampled at the edge, read data valid the next cycle
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[address] <= data;
    end
    q <= mem[address];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (wren) begin
      check("wren_busy", {31'd0, busy}, 32'd1);
      if (wr_cnt < 6) wlog[wr_cnt] = '{a: address, d: data};
      wr_cnt++;
      if (sb_en) begin
        check("sb_underflow", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("sb_addr", {24'd0, address}, {24'd0, e.a});
          check("sb_data", {24'd0, data}, {24'd0, e.d});
        end
      end
    end
  end

  task automatic build_model(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] jj;
    logic [7:0] kb [3];
    logic [7:0] t;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    jj = 8'd0;
    exp_q.delete();
    for (int ii = 0; ii < 256; ii++) begin
      jj = jj + s[ii] + kb[ii % 3];
      exp_q.push_back('{a: 8'(ii), d: s[jj]});
      exp_q.push_back('{a: jj, d: s[ii]});
      t = s[ii];
      s[ii] = s[jj];
      s[jj] = t;
    end
    for (int k = 0; k < 256; k++) exp_s[k] = s[k];
  endtask

  task automatic init_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  task automatic run_pass(input logic [23:0] key, input bit disturb, input string tag);
    int t0;
    int n;
    int de;
    int d0;
    int diffs;
    bit got;
    init_mem();
    build_model(key);
    sb_en  = 1'b1;
    wr_cnt = 0;
    d0     = done_cnt;
    @(negedge clk);
    secret_key = key;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0    = edge_cnt;
    check({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
    n   = 0;
    de  = 0;
    got = 1'b0;
    while (!got && n < 3000) begin
      @(negedge clk);
      n++;
      if (disturb) begin
        if (n == 1000) begin
          start      = 1'b1;
          secret_key = 24'hFFFFFF;
        end else if (n == 1001) begin
          start = 1'b0;
        end
      end
      if (done) begin
        got = 1'b1;
        de  = edge_cnt;
      end
    end
    check({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    check({tag, "_done_edge"}, 32'(de - t0), 32'd2048);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
    @(negedge clk);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_after"}, {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_wren_cycles"}, 32'(wr_cnt), 32'd512);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
    diffs = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== exp_s[k]) diffs++;
    check({tag, "_final_s_diffs"}, 32'(diffs), 32'd0);
  endtask

  initial begin
    int d0;
    total      = 0;
    bad        = 0;
    done_cnt   = 0;
    wr_cnt     = 0;
    sb_en      = 1'b0;
    mem_init   = 1'b0;
    reset      = 1'b1;
    start      = 1'b0;
    secret_key = 24'd0;
    repeat (3) @(negedge clk);
    check("rst_address", {24'd0, address}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    run_pass(24'h000249, 1'b0, "k249");
    check("w0_addr", {24'd0, wlog[0].a}, 32'h00);
    check("w0_data", {24'd0, wlog[0].d}, 32'h00);
    check("w1_addr", {24'd0, wlog[1].a}, 32'h00);
    check("w2_addr", {24'd0, wlog[2].a}, 32'h01);
    check("w2_data", {24'd0, wlog[2].d}, 32'h03);
    check("w3_addr", {24'd0, wlog[3].a}, 32'h03);
    check("w3_data", {24'd0, wlog[3].d}, 32'h01);
    check("w4_addr", {24'd0, wlog[4].a}, 32'h02);
    check("w4_data", {24'd0, wlog[4].d}, 32'h4E);
    check("w5_addr", {24'd0, wlog[5].a}, 32'h4E);
    check("w5_data", {24'd0, wlog[5].d}, 32'h02);

    run_pass(24'h000000, 1'b0, "k000");
    check("k0_self_addr", {24'd0, wlog[0].a}, 32'h00);
    check("k0_self_data", {24'd0, wlog[1].d}, 32'h00);

    run_pass(24'h000249, 1'b1, "disturb");

    // reset in the middle of a pass
    init_mem();
    sb_en = 1'b0;
    d0    = done_cnt;
    @(negedge clk);
    secret_key = 24'h000249;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (500) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wren", {31'd0, wren}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_address", {24'd0, address}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    check("midrst_idle", {31'd0, busy}, 32'd0);
    run_pass(24'h000249, 1'b0, "after_rst");

    // reset and start together: reset wins
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_start_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("rst_start_still_idle", {31'd0, busy}, 32'd0);
    run_pass(24'h000249, 1'b0, "post_both");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
